// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RISC-V control FSM with memory-wait timeout
// Optional trap state on unsupported opcodes: define MULTICYCLE_CTRL_FSM_TRAP_EN.
module multicycle_ctrl_fsm #(
  parameter int MEM_TO_W   = 8,
  parameter int MEM_TO_MAX = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCUpdate,
  output logic       Branch,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       mem_req,
  output logic       timeout,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12,
    S_JALR     = 4'd13,
    S_TRAP     = 4'd14,
    S_RSVD     = 4'd15
  } state_t;

  localparam logic [MEM_TO_W-1:0] TO_LIMIT = MEM_TO_W'(MEM_TO_MAX);

  state_t              state_q, state_d;
  logic [MEM_TO_W-1:0] wait_cnt;
  logic                abandon;
  logic                timeout_d;

  // An access is abandoned only if memory is still not ready at the limit.
  assign abandon = (wait_cnt == TO_LIMIT) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    mem_req   = 1'b0;
    case (state_q)
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == 7'b1101111) ? 3'b011 : 3'b010;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BRANCH;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          7'b1100111:             state_d = S_JALR;
`ifdef MULTICYCLE_CTRL_FSM_TRAP_EN
          default:                state_d = S_TRAP;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'b001 : 3'b000;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (abandon) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        ImmSrc   = 3'b001;
        MemWrite = mem_ready;
        if (mem_ready) state_d = S_FETCH;
        else if (abandon) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        ImmSrc  = 3'b010;
        Branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_LUI: begin
        ImmSrc    = 3'b100;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCUpdate  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_CTRL_FSM_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        // S_FETCH, and the unused encoding which behaves identically.
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else if (abandon) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
    endcase
  end

  // Any state change (or a timeout re-entering FETCH) starts a fresh wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (timeout_d || (state_d != state_q)) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_FSM_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else if ((state_q == S_DECODE) && (state_d == S_TRAP)) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign timeout = timeout_d;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized bench for multicycle_ctrl_fsm against a path-queue model
module tb_multicycle_ctrl_fsm;

  localparam int TO_MAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic       MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       mem_req, timeout, illegal;
  logic [3:0] state;

  multicycle_ctrl_fsm #(.MEM_TO_W(8), .MEM_TO_MAX(TO_MAX)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .PCUpdate(PCUpdate), .Branch(Branch), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .mem_req(mem_req),
    .timeout(timeout), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: current state number, wait cycles so far, and the remaining path of the instruction.
  int   m_state;
  int   m_wait;
  int   path[$];
  logic m_illegal;

  logic [6:0] ops[10];

  // Field order: MemWrite RegWrite IRWrite AdrSrc PCUpdate Branch | ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc mem_req
  function automatic logic [17:0] exp_ctrl(input int st, input logic [6:0] o, input logic mr);
    case (st)
      0, 15: return {1'b0, 1'b0, mr, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b1};
      1:  return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, (o == 7'b1101111) ? 3'b011 : 3'b010, 1'b0};
      2:  return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, o[5] ? 3'b001 : 3'b000, 1'b0};
      3:  return {6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};
      4:  return {6'b010000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
      5:  return {mr, 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1};
      6:  return {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};
      7:  return {6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
      8:  return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 1'b0};
      9:  return {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0};
      10: return {6'b000001, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 1'b0};
      11: return {6'b010000, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100, 1'b0};
      12: return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b100, 1'b0};
      13: return {6'b000010, 2'b10, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0};
      default: return 18'd0;
    endcase
  endfunction

  task automatic set_route(input logic [6:0] o);
    path.delete();
    case (o)
      7'b0000011: path = '{2, 3, 4};
      7'b0100011: path = '{2, 5};
      7'b0110011: path = '{6, 7};
      7'b0010011: path = '{8, 7};
      7'b1101111: path = '{9, 7};
      7'b1100011: path = '{10};
      7'b0110111: path = '{11};
      7'b0010111: path = '{12, 7};
      7'b1100111: path = '{13, 7};
      default: begin
`ifdef MULTICYCLE_CTRL_FSM_TRAP_EN
        path = '{14};
        m_illegal = 1'b1;
`endif
      end
    endcase
  endtask

  task automatic goto_next(input logic [6:0] o);
    m_wait = 0;
    if (m_state == 0) m_state = 1;
    else begin
      if (m_state == 1) set_route(o);
      m_state = (path.size() > 0) ? path.pop_front() : 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_wait = 0;
    m_illegal = 1'b0;
    path.delete();
  endtask

  // Called at a falling edge; drives inputs, checks outputs, advances the model, waits for the next falling edge.
  task automatic step(input logic [6:0] o, input logic mr);
    logic is_mem;
    logic exp_to;
    op = o;
    mem_ready = mr;
    #1;
    is_mem = (m_state == 0) || (m_state == 3) || (m_state == 5);
    exp_to = is_mem && !mr && (m_wait == TO_MAX);
    check("state", {28'd0, state}, m_state);
    check("ctrl", {14'd0, MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch, ResultSrc,
                   ALUSrcA, ALUSrcB, ALUOp, ImmSrc, mem_req}, {14'd0, exp_ctrl(m_state, o, mr)});
    check("timeout", {31'd0, timeout}, {31'd0, exp_to});
    check("illegal", {31'd0, illegal}, {31'd0, m_illegal});
    if (is_mem) begin
      if (mr) goto_next(o);
      else if (m_wait == TO_MAX) begin
        m_wait = 0;
        m_state = 0;
        path.delete();
      end else m_wait++;
    end else if (m_state != 14) goto_next(o);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks the asynchronous effect before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic stall;
    logic [6:0] cur_op;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1111111};
    reset = 1'b1;
    op = 7'd0;
    mem_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;

    // Load with memory always ready: 0,1,2,3,4,0.
    repeat (6) step(7'b0000011, 1'b1);
    // Store with three wait cycles in MEMWRITE.
    step(7'b0100011, 1'b1);
    step(7'b0100011, 1'b1);
    step(7'b0100011, 1'b1);
    repeat (3) step(7'b0100011, 1'b0);
    step(7'b0100011, 1'b1);
    // LUI then JALR.
    repeat (4) step(7'b0110111, 1'b1);
    repeat (5) step(7'b1100111, 1'b1);
    // Unsupported opcode.
    step(7'b1111111, 1'b1);
    step(7'b1111111, 1'b1);
    repeat (2) step(7'b1111111, 1'b1);
    check("illegal_path", {28'd0, state}, m_state);
    if (m_state == 14) do_reset();

    // Reset in the middle of a MEMREAD wait.
    step(7'b0000011, 1'b1);
    step(7'b0000011, 1'b1);
    step(7'b0000011, 1'b1);
    repeat (2) step(7'b0000011, 1'b0);
    do_reset();
    // FETCH timeout: pulse on the 5th cycle, then a fresh count.
    repeat (9) step(7'b0110011, 1'b0);
    step(7'b0110011, 1'b1);

    stall = 1'b0;
    cur_op = ops[0];
    for (int i = 0; i < 1500; i++) begin
      if (m_state == 14 || $urandom_range(0, 99) == 0) do_reset();
      if (m_state == 0 && m_wait == 0) begin
        cur_op = ops[$urandom_range(0, 9)];
        stall = ($urandom_range(0, 7) == 0);
      end
      step(cur_op, stall ? 1'b0 : ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
